// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier slice: default operand width,
// product width and the result-collector state encoding.
package booth_pkg;

  localparam int unsigned W_DEF  = 5;
  localparam int unsigned PW_DEF = 2 * W_DEF;

  typedef enum logic {
    IDLE   = 1'b0,
    GOT_HI = 1'b1
  } collState_t;

endpackage

// File: rtl/booth_result_collector_if.sv
// Multiplier-to-collector and collector-to-consumer signals.
// slave = collector side, master = multiplier/consumer side.
interface booth_result_collector_if #(
  parameter int unsigned W = booth_pkg::W_DEF
);

  logic           mul_done;
  logic           mul_sel;
  logic [W-1:0]   mul_data;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_data;
  logic           full;
  logic           err;
  logic           err_clr;

  modport master (
    output mul_done, mul_sel, mul_data, out_ready, err_clr,
    input  out_valid, out_data, full, err
  );

  modport slave (
    input  mul_done, mul_sel, mul_data, out_ready, err_clr,
    output out_valid, out_data, full, err
  );

endinterface

// File: rtl/booth_result_collector_prod_fifo.sv
// Circular synchronous FIFO for assembled products; a push into a full FIFO
// without a simultaneous pop is dropped and flagged on drop.
module prod_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rdPtr;
  logic [AW-1:0]    wrPtr;
  logic             doPush;
  logic             doPop;
  logic             isFull;
  logic             isEmpty;

  assign isFull  = (count == FULL_CNT);
  assign isEmpty = (count == '0);
  assign doPop   = pop & ~isEmpty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign doPush  = push & (~isFull | doPop);
  assign drop    = push & isFull & ~doPop;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

  assign dout = isEmpty ? '0 : mem[rdPtr];

endmodule

// File: rtl/booth_result_collector.sv
// Reassembles serial hi/lo half-words into 2W-bit products and queues them.
// Optional sticky error status under `ERR_STATUS_EN.
module booth_result_collector
  import booth_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  booth_result_collector_if.slave   bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  collState_t    state;
  collState_t    nextState;
  logic [W-1:0]  hiReg;
  logic [W-1:0]  hiNext;
  logic          push;
  logic          seqErr;
  logic          pop;
  logic          drop;
  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hiReg <= '0;
    end else begin
      state <= nextState;
      hiReg <= hiNext;
    end
  end

  always_comb begin
    nextState = state;
    hiNext    = hiReg;
    push      = 1'b0;
    seqErr    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.mul_done) begin
          if (bus.mul_sel) begin
            seqErr = 1'b1;
          end else begin
            hiNext    = bus.mul_data;
            nextState = GOT_HI;
          end
        end
      end
      GOT_HI: begin
        // The low word must follow the high word with no gap.
        if (!bus.mul_done) begin
          seqErr    = 1'b1;
          nextState = IDLE;
        end else if (bus.mul_sel) begin
          push      = 1'b1;
          nextState = IDLE;
        end else begin
          seqErr = 1'b1;
          hiNext = bus.mul_data;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  assign pop = bus.out_valid & bus.out_ready;

  prod_fifo #(
    .WIDTH (2 * W),
    .DEPTH (DEPTH)
  ) uFifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({hiReg, bus.mul_data}),
    .dout  (bus.out_data),
    .count (count),
    .drop  (drop)
  );

  assign bus.out_valid = (count != '0);
  assign bus.full      = (count == FULL_CNT);

`ifdef ERR_STATUS_EN
  logic errReg;

  // A new error in the clearing cycle takes priority over err_clr.
  always_ff @(posedge clk) begin
    if (rst)                  errReg <= 1'b0;
    else if (seqErr | drop)   errReg <= 1'b1;
    else if (bus.err_clr)     errReg <= 1'b0;
  end

  assign bus.err = errReg;
`else
  logic [2:0] unusedErrBits;
  assign unusedErrBits = {bus.err_clr, seqErr, drop};
  assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_booth_result_collector.sv
// Self-checking bench for booth_result_collector: directed vector table,
// hand-written corner sequences and random traffic against a queue model.
module tb_booth_result_collector;

  localparam int unsigned W     = 5;
  localparam int unsigned DEPTH = 2;
`ifdef ERR_STATUS_EN
  localparam logic ERRV = 1'b1;
`else
  localparam logic ERRV = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  booth_result_collector_if #(.W(W)) bus ();

  booth_result_collector #(
    .W     (W),
    .DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nAssert = 0;
  int nFail   = 0;

  // Reference model: product queue, pending high word, sticky error.
  int   q[$];
  bit   havePend = 1'b0;
  int   pendVal  = 0;
  bit   mErr     = 1'b0;

  typedef struct {
    logic         done;
    logic         sel;
    logic [W-1:0] data;
    logic         ready;
    logic         expValid;
    logic [9:0]   expData;
    logic         expFull;
    logic         expErr;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic modelStep(input logic r, input logic d, input logic s,
                           input logic [W-1:0] dat, input logic rdy, input logic clr);
    bit e;
    bit pushing;
    int prod;
    bit popping;
    e = 1'b0;
    pushing = 1'b0;
    prod = 0;
    if (r) begin
      q.delete();
      havePend = 1'b0;
      mErr = 1'b0;
      return;
    end
    popping = rdy && (q.size() > 0);
    if (!havePend) begin
      if (d && !s) begin
        havePend = 1'b1;
        pendVal  = int'(dat);
      end else if (d && s) begin
        e = 1'b1;
      end
    end else begin
      if (d && s) begin
        pushing  = 1'b1;
        prod     = pendVal * (1 << W) + int'(dat);
        havePend = 1'b0;
      end else if (d) begin
        e = 1'b1;
        pendVal = int'(dat);
      end else begin
        e = 1'b1;
        havePend = 1'b0;
      end
    end
    if (pushing && q.size() == DEPTH && !popping) begin
      pushing = 1'b0;
      e = 1'b1;
    end
    if (popping) void'(q.pop_front());
    if (pushing) q.push_back(prod);
`ifdef ERR_STATUS_EN
    if (e)        mErr = 1'b1;
    else if (clr) mErr = 1'b0;
`endif
  endtask

  task automatic tick(input logic r, input logic d, input logic s,
                      input logic [W-1:0] dat, input logic rdy, input logic clr);
    rst           = r;
    bus.mul_done  = d;
    bus.mul_sel   = s;
    bus.mul_data  = dat;
    bus.out_ready = rdy;
    bus.err_clr   = clr;
    modelStep(r, d, s, dat, rdy, clr);
    @(posedge clk);
    #1;
    chk("model_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    chk("model_data",  32'(bus.out_data),  (q.size() > 0) ? q[0] : 0);
    chk("model_full",  32'(bus.full),      32'(q.size() == DEPTH));
    chk("model_err",   32'(bus.err),       32'(mErr));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit expectLo;
    logic d;
    logic s;

    // done sel data ready | valid data full err
    vecs[0] = '{1'b1, 1'b0, 5'h01, 1'b1, 1'b0, 10'h000, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 5'h06, 1'b1, 1'b1, 10'h026, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 5'h00, 1'b1, 1'b0, 10'h000, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 5'h01, 1'b1, 1'b0, 10'h000, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 5'h06, 1'b1, 1'b1, 10'h026, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 5'h1F, 1'b1, 1'b0, 10'h000, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 5'h1F, 1'b1, 1'b1, 10'h3FF, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 5'h00, 1'b1, 1'b0, 10'h000, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 5'h00, 1'b1, 1'b1, 10'h000, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 5'h00, 1'b1, 1'b0, 10'h000, 1'b0, 1'b0};

    bus.mul_done = 1'b0; bus.mul_sel = 1'b0; bus.mul_data = '0;
    bus.out_ready = 1'b0; bus.err_clr = 1'b0;

    // Reset state
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_data",  32'(bus.out_data),  0);
    chk("rst_full",  32'(bus.full),      0);
    chk("rst_err",   32'(bus.err),       0);

    // Basic product and back-to-back products
    for (int i = 0; i < 10; i++) begin
      tick(0, vecs[i].done, vecs[i].sel, vecs[i].data, vecs[i].ready, 0);
      chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].expValid));
      chk($sformatf("vec%0d_data", i),  32'(bus.out_data),  32'(vecs[i].expData));
      chk($sformatf("vec%0d_full", i),  32'(bus.full),      32'(vecs[i].expFull));
      chk($sformatf("vec%0d_err", i),   32'(bus.err),       32'(vecs[i].expErr));
    end

    // Overflow under consumer stall
    tick(0, 1, 0, 5'h01, 0, 0); tick(0, 1, 1, 5'h02, 0, 0);
    chk("ovf_first", 32'(bus.out_data), 32'h022);
    chk("ovf_notfull", 32'(bus.full), 0);
    tick(0, 1, 0, 5'h03, 0, 0); tick(0, 1, 1, 5'h04, 0, 0);
    chk("ovf_full", 32'(bus.full), 1);
    chk("ovf_err_before", 32'(bus.err), 0);
    tick(0, 1, 0, 5'h05, 0, 0); tick(0, 1, 1, 5'h06, 0, 0);
    chk("ovf_full_kept", 32'(bus.full), 1);
    chk("ovf_head_kept", 32'(bus.out_data), 32'h022);
    chk("ovf_err", 32'(bus.err), 32'(ERRV));
    tick(0, 0, 0, 0, 1, 0);
    chk("ovf_second", 32'(bus.out_data), 32'h064);
    tick(0, 0, 0, 0, 1, 0);
    chk("ovf_drained", 32'(bus.out_valid), 0);
    tick(0, 0, 0, 0, 0, 1);
    chk("ovf_errclr", 32'(bus.err), 0);

    // Full with simultaneous pop
    tick(0, 1, 0, 5'h05, 0, 0); tick(0, 1, 1, 5'h01, 0, 0);
    tick(0, 1, 0, 5'h02, 0, 0); tick(0, 1, 1, 5'h02, 0, 0);
    tick(0, 1, 0, 5'h03, 0, 0); tick(0, 1, 1, 5'h07, 1, 0);
    chk("fpop_full", 32'(bus.full), 1);
    chk("fpop_head", 32'(bus.out_data), 32'h042);
    chk("fpop_err", 32'(bus.err), 0);
    tick(0, 0, 0, 0, 1, 0);
    chk("fpop_last", 32'(bus.out_data), 32'h067);
    tick(0, 0, 0, 0, 1, 0);
    chk("fpop_empty", 32'(bus.out_valid), 0);

    // Sequence errors
    tick(0, 1, 1, 5'h07, 1, 0);
    chk("seq_lo_idle_valid", 32'(bus.out_valid), 0);
    chk("seq_lo_idle_err", 32'(bus.err), 32'(ERRV));
    tick(0, 0, 0, 0, 1, 1);
    chk("seq_clr", 32'(bus.err), 0);
    tick(0, 1, 0, 5'h09, 1, 0); tick(0, 0, 0, 0, 1, 0);
    chk("seq_gap_valid", 32'(bus.out_valid), 0);
    chk("seq_gap_err", 32'(bus.err), 32'(ERRV));
    tick(0, 1, 0, 5'h09, 1, 1);
    tick(0, 1, 1, 5'h04, 1, 0);
    chk("seq_hi_clr_data", 32'(bus.out_data), 32'h124);
    tick(0, 1, 0, 5'h01, 0, 1); tick(0, 1, 0, 5'h02, 0, 0); tick(0, 1, 1, 5'h03, 0, 0);
    chk("seq_restart", 32'(bus.out_data), 32'h124);
    tick(0, 0, 0, 0, 1, 0);
    chk("seq_restart_prod", 32'(bus.out_data), 32'h043);
    tick(0, 1, 1, 5'h04, 1, 1);
    chk("seq_err_wins", 32'(bus.err), 32'(ERRV));
    tick(0, 0, 0, 0, 1, 1);
    chk("seq_clr2", 32'(bus.err), 0);

    // Reset mid-assembly with a product buffered
    tick(0, 1, 0, 5'h01, 0, 0); tick(0, 1, 1, 5'h02, 0, 0);
    tick(0, 1, 0, 5'h0B, 0, 0);
    tick(1, 0, 0, 0, 0, 0);
    chk("mrst_valid", 32'(bus.out_valid), 0);
    chk("mrst_data",  32'(bus.out_data),  0);
    chk("mrst_full",  32'(bus.full),      0);
    chk("mrst_err",   32'(bus.err),       0);
    tick(0, 1, 1, 5'h0C, 0, 0);
    chk("mrst_lo_valid", 32'(bus.out_valid), 0);
    chk("mrst_lo_full",  32'(bus.full),      0);
    tick(0, 0, 0, 0, 1, 1);
    chk("mrst_still_empty", 32'(bus.out_valid), 0);

    // Random traffic, mostly well-formed pairs with occasional protocol slips
    expectLo = 1'b0;
    for (int n = 0; n < 600; n++) begin
      d = ($urandom_range(0, 5) != 0);
      s = ($urandom_range(0, 7) == 0) ? ~expectLo : expectLo;
      if (d) expectLo = ~s;
      tick(0, d, s, W'($urandom), ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule

// File: doc/booth_result_collector.md
# booth_result_collector

Downstream stage of the Booth multiplier. The multiplier presents its 2W-bit product serially on a W-bit bus over two consecutive `done` cycles: high word first (`sel`=0), then low word (`sel`=1). This block reassembles the two halves into one 2W-bit product and buffers it in a small FIFO. It presents the result to the consumer with a valid/ready handshake. The multiplier has no backpressure, so the block also detects sequence errors and overflow.

## Interface
- W, 5, multiplier operand width; product width is 2W.
- DEPTH, 2, FIFO entries (power of two, ≥2).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- mul_done  in  1  multiplier half-word strobe.
- mul_sel  in  1  0 = high word (accumulator), 1 = low word (multiplier register).
- mul_data  in  W  half-word, valid when mul_done=1.
- out_valid  out  1  FIFO head holds a product.
- out_ready  in  1  consumer accepts head.
- out_data  out  2W  product at FIFO head, {hi, lo}.
- full  out  1  FIFO count == DEPTH.
- err  out  1  sticky error flag; present only with ERR_STATUS_EN, otherwise tied 0.
- err_clr  in  1  clears err; ignored without ERR_STATUS_EN.

## Operation
- Assembly FSM with 2 states: IDLE, GOT_HI. A W-bit hi_reg holds the captured high word.
- IDLE:
  - mul_done & !mul_sel → hi_reg ← mul_data, go to GOT_HI.
  - mul_done & mul_sel → sequence error; data discarded; stay in IDLE.
  - Otherwise stay in IDLE.
- GOT_HI:
  - mul_done & mul_sel → push {hi_reg, mul_data}, go to IDLE.
  - mul_done & !mul_sel → sequence error; hi_reg ← mul_data; stay in GOT_HI (restart).
  - !mul_done → sequence error (low word must be back-to-back); go to IDLE; nothing pushed.
- FIFO: circular, with rd_ptr and wr_ptr of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
  - pop = out_valid & out_ready.
  - Push while full with no simultaneous pop → product dropped, overflow error. FIFO contents are unchanged.
  - Push while full with a simultaneous pop → both happen; count stays DEPTH.
  - Push and pop when not full → count unchanged.
  - Pop when empty cannot occur, because out_valid=0.
- out_valid = (count != 0). out_data = mem[rd_ptr], driven from registers. out_data is undefined-but-stable when out_valid=0; it is driven as 0.
- No arithmetic on data. Concatenation only; no sign extension.

## Timing
- Reset values: state=IDLE, count=0, pointers=0, out_valid=0, out_data=0, full=0, err=0.
- Latency: a product pushed in cycle N (the low-word cycle) has out_valid=1 in cycle N+1.
- Throughput: one product per two cycles. This exceeds the multiplier rate, so overflow occurs only under consumer stall.
- out_valid and out_data stay stable while out_ready=0. The handshake completes in any cycle where both are 1.
- full updates the cycle after the push or pop that changes count.
- rst mid-assembly discards hi_reg and all FIFO contents. The first mul_done after reset is treated per the IDLE rules.

## Configuration
- ERR_STATUS_EN defined:
  - err is set the cycle after any sequence error or overflow drop.
  - err holds until an err_clr cycle.
  - If err_clr and a new error occur in the same cycle, the error wins (err stays 1).
- ERR_STATUS_EN undefined:
  - err is constant 0 and err_clr is unused.
  - Sequence errors and drops still behave exactly as above (silent discard).

## Structure
- Shared package booth_pkg holds:
  - the default W and the derived product width;
  - the collector state encoding, IDLE=1'b0 and GOT_HI=1'b1.
- Sub-module prod_fifo, a synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/din/dout/count, and drop-on-full.
- The top level holds the assembly FSM, hi_reg and the err logic.

## Test plan
- Basic product: W=5. Drive mul_done=1 with sel=0, data=5'b00001, then the next cycle sel=1, data=5'b00110, with out_ready=1. Required: the following cycle shows out_valid=1 and out_data=10'h026, then out_valid=0.
- Back-to-back products: three products (10'h026, 10'h3FF, 10'h000), each a two-cycle pair with no gaps, out_ready=1. Required: all three appear in order, one cycle after each low word; err=0.
- Overflow: out_ready=0; push three products with DEPTH=2. Required:
  - full=1 after the second product;
  - the third product is dropped;
  - err=1 (with ERR_STATUS_EN);
  - raising out_ready yields only the first two products.
- Full with simultaneous pop: FIFO full, out_ready=1 in the same cycle as the low-word push. Required: count stays 2, no drop, err=0, and the new product is the last out.
- Sequence errors:
  - A low word in IDLE is ignored.
  - A high word followed by an idle cycle leaves no product.
  - Two high words in a row (5'h01 then 5'h02), then a low word 5'h03, yields 10'h043.
  - err=1 after the first error; err_clr returns it to 0.
- Reset mid-assembly: high word captured, then rst pulsed for one cycle, then a low word. Required: no output and FIFO empty. Every output is at its reset value during and after the rst cycle.
